// File: rtl/network_layer_tx.sv
// IPv4 transmit layer: builds the 20-byte header and its checksum, then streams
// transport payload words to the MAC behind a ready/valid handshake.
module network_layer_tx #(
   parameter int         MAX_PAYLOAD = 1480,
   parameter logic [2:0] DEF_FLAGS   = 3'b000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tx_req,
   input  logic [15:0] payload_len,
   input  logic [15:0] packet_id_i,
   input  logic [7:0]  ttl_i,
   input  logic [7:0]  prot_type_i,
   input  logic [31:0] source_addr_i,
   input  logic [31:0] dest_addr_i,
   output logic        tx_busy,
   output logic        len_err_o,
   output logic        upper_rdy,
   input  logic        upper_op,
   input  logic        upper_op_end,
   input  logic [31:0] upper_data,
   output logic        send_op_st,
   output logic        send_op,
   output logic        send_op_end,
   output logic [31:0] send_data,
   input  logic        send_rdy,
   output logic [15:0] eth_type_o,
   output logic [15:0] checksum_o
);

   typedef enum logic [2:0] {IDLE, CALC, FOLD, HDR, DATA, PAD} state_t;

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [19:0] acc_q, acc_d;
   logic [15:0] total_len_q, total_len_d;
   logic [15:0] nwords_q, nwords_d;
   logic [15:0] id_q, id_d;
   logic [7:0]  ttl_q, ttl_d;
   logic [7:0]  prot_q, prot_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] checksum_q, checksum_d;
   logic        len_err_q, len_err_d;

   logic        len_ok;
   logic        last_word;
   logic [15:0] hdr_csum;
   logic [31:0] hdr_w;
   logic [16:0] nwords_sum;
   logic [16:0] fold1;
   logic [15:0] fold2;

   assign eth_type_o = 16'h0800;
   assign checksum_o = checksum_q;
   assign len_err_o  = len_err_q;
   assign tx_busy    = (state_q != IDLE);

   assign len_ok     = (payload_len != 16'd0) && (payload_len <= 16'(MAX_PAYLOAD));
   assign last_word  = ((cnt_q + 16'd1) == nwords_q);
   assign nwords_sum = {1'b0, payload_len} + 17'd3;
   assign fold1      = {1'b0, acc_q[15:0]} + {13'h0, acc_q[19:16]};
   assign fold2      = fold1[15:0] + {15'h0, fold1[16]};

   // The checksum field reads as zero while the sum is being accumulated.
   assign hdr_csum = (state_q == HDR) ? checksum_q : 16'h0000;

   always_comb begin
      hdr_w = 32'h0;
      case (idx_q)
         3'd0:    hdr_w = {4'h4, 4'h5, 8'h00, total_len_q};
         3'd1:    hdr_w = {id_q, DEF_FLAGS, 13'h0};
         3'd2:    hdr_w = {ttl_q, prot_q, hdr_csum};
         3'd3:    hdr_w = src_q;
         3'd4:    hdr_w = dst_q;
         default: hdr_w = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         cnt_q       <= 16'd0;
         acc_q       <= 20'd0;
         total_len_q <= 16'd0;
         nwords_q    <= 16'd0;
         id_q        <= 16'd0;
         ttl_q       <= 8'd0;
         prot_q      <= 8'd0;
         src_q       <= 32'd0;
         dst_q       <= 32'd0;
         checksum_q  <= 16'd0;
         len_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         total_len_q <= total_len_d;
         nwords_q    <= nwords_d;
         id_q        <= id_d;
         ttl_q       <= ttl_d;
         prot_q      <= prot_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         checksum_q  <= checksum_d;
         len_err_q   <= len_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      total_len_d = total_len_q;
      nwords_d    = nwords_q;
      id_d        = id_q;
      ttl_d       = ttl_q;
      prot_d      = prot_q;
      src_d       = src_q;
      dst_d       = dst_q;
      checksum_d  = checksum_q;
      len_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_req) begin
               if (!len_ok) begin
                  len_err_d = 1'b1;
               end else begin
                  total_len_d = payload_len + 16'd20;
                  nwords_d    = 16'(nwords_sum >> 2);
                  id_d        = packet_id_i;
                  ttl_d       = ttl_i;
                  prot_d      = prot_type_i;
                  src_d       = source_addr_i;
                  dst_d       = dest_addr_i;
                  acc_d       = 20'd0;
                  idx_d       = 3'd0;
                  state_d     = CALC;
               end
            end
         end
         CALC: begin
            acc_d = acc_q + {4'h0, hdr_w[31:16]} + {4'h0, hdr_w[15:0]};
            if (idx_q == 3'd4) begin
               idx_d   = 3'd0;
               state_d = FOLD;
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         FOLD: begin
            checksum_d = ~fold2;
            state_d    = HDR;
         end
         HDR: begin
            if (send_rdy) begin
               if (idx_q == 3'd4) begin
                  idx_d   = 3'd0;
                  cnt_d   = 16'd0;
                  state_d = DATA;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         DATA: begin
            if (upper_op && send_rdy) begin
               cnt_d = cnt_q + 16'd1;
               if (last_word) begin
                  state_d = IDLE;
               end else if (upper_op_end) begin
                  len_err_d = 1'b1;
                  state_d   = PAD;
               end
            end
         end
         PAD: begin
            if (send_rdy) begin
               cnt_d = cnt_q + 16'd1;
               if (last_word) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Payload words bypass all registers so the transport sees MAC backpressure directly.
   always_comb begin
      upper_rdy   = 1'b0;
      send_op     = 1'b0;
      send_op_st  = 1'b0;
      send_op_end = 1'b0;
      send_data   = 32'h0;
      case (state_q)
         HDR: begin
            send_op    = 1'b1;
            send_op_st = (idx_q == 3'd0);
            send_data  = hdr_w;
         end
         DATA: begin
            upper_rdy   = send_rdy;
            send_op     = upper_op;
            send_data   = upper_data;
            send_op_end = upper_op && last_word;
         end
         PAD: begin
            send_op     = 1'b1;
            send_op_end = last_word;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_network_layer_tx.sv
// Scoreboard bench for network_layer_tx: expected MAC words are queued with
// each request and checked by an independent monitor as they transfer.
module tb_network_layer_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tx_req;
   logic [15:0] payload_len;
   logic [15:0] packet_id_i;
   logic [7:0]  ttl_i;
   logic [7:0]  prot_type_i;
   logic [31:0] source_addr_i;
   logic [31:0] dest_addr_i;
   logic        tx_busy;
   logic        len_err_o;
   logic        upper_rdy;
   logic        upper_op;
   logic        upper_op_end;
   logic [31:0] upper_data;
   logic        send_op_st;
   logic        send_op;
   logic        send_op_end;
   logic [31:0] send_data;
   logic        send_rdy;
   logic [15:0] eth_type_o;
   logic [15:0] checksum_o;

   network_layer_tx dut (
      .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .payload_len(payload_len),
      .packet_id_i(packet_id_i), .ttl_i(ttl_i), .prot_type_i(prot_type_i),
      .source_addr_i(source_addr_i), .dest_addr_i(dest_addr_i),
      .tx_busy(tx_busy), .len_err_o(len_err_o), .upper_rdy(upper_rdy),
      .upper_op(upper_op), .upper_op_end(upper_op_end), .upper_data(upper_data),
      .send_op_st(send_op_st), .send_op(send_op), .send_op_end(send_op_end),
      .send_data(send_data), .send_rdy(send_rdy), .eth_type_o(eth_type_o),
      .checksum_o(checksum_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        st;
      logic        en;
      logic [31:0] d;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] tq[$];
   int          t_end_at = 0;
   int          t_pos    = 0;
   int          t_taken  = 0;
   int          n_cmp    = 0;
   int          n_bad    = 0;
   int          cyc      = 0;
   int          req_cyc  = 0;
   int          err_cnt  = 0;
   logic        bp_mode  = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: pops one expected beat per accepted MAC word.
   initial begin
      beat_t       e;
      logic        hold_chk;
      logic [31:0] hold_data;
      hold_chk  = 1'b0;
      hold_data = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_chk = 1'b0;
         end else begin
            if (len_err_o) err_cnt++;
            if (hold_chk)
               checkOutput("held_word", {31'd0, send_op, send_data}, {31'd0, 1'b1, hold_data});
            if (upper_rdy)
               checkOutput("upper_rdy_vs_send_rdy", {63'd0, send_rdy}, 64'd1);
            if (send_op && send_rdy) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("[TB] FAIL unexpected_word: got %0h, required no transfer", send_data);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("frame_word", {30'd0, send_op_st, send_op_end, send_data},
                              {30'd0, e.st, e.en, e.d});
                  if (send_op_st)
                     checkOutput("first_word_latency", 64'(cyc - req_cyc), 64'd7);
               end
            end
            hold_chk  = send_op && !send_rdy;
            hold_data = send_data;
         end
      end
   end

   // Transport model: presents queued words, marks upper_op_end on word t_end_at.
   initial begin
      logic take;
      upper_op     = 1'b0;
      upper_op_end = 1'b0;
      upper_data   = 32'h0;
      forever begin
         @(negedge clk);
         take = upper_op && upper_rdy && rst_n;
         @(posedge clk);
         #1;
         if (take && tq.size() > 0) begin
            void'(tq.pop_front());
            t_pos++;
            t_taken++;
         end
         upper_op     = (tq.size() > 0);
         upper_data   = (tq.size() > 0) ? tq[0] : 32'h0;
         upper_op_end = upper_op && ((t_pos + 1) == t_end_at);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (bp_mode) send_rdy = ~send_rdy;
   end

   task automatic loadTransport(input logic [31:0] w0, w1, w2, w3, input int n, input int end_at);
      logic [31:0] w[4];
      w = '{w0, w1, w2, w3};
      tq.delete();
      for (int i = 0; i < n; i++) tq.push_back(w[i]);
      t_pos    = 0;
      t_taken  = 0;
      t_end_at = end_at;
   endtask

   task automatic pushHdr(input logic [31:0] w0, w1, w2, w3, w4);
      exp_q.push_back('{1'b1, 1'b0, w0});
      exp_q.push_back('{1'b0, 1'b0, w1});
      exp_q.push_back('{1'b0, 1'b0, w2});
      exp_q.push_back('{1'b0, 1'b0, w3});
      exp_q.push_back('{1'b0, 1'b0, w4});
   endtask

   task automatic pushData(input logic [31:0] w0, w1, w2, w3, input int n);
      logic [31:0] w[4];
      w = '{w0, w1, w2, w3};
      for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, (i == n - 1), w[i]});
   endtask

   task automatic applyStimulus(input logic [15:0] len, id, input logic [7:0] ttl, prot,
                                input logic [31:0] src, dst);
      @(posedge clk);
      #1;
      payload_len   = len;
      packet_id_i   = id;
      ttl_i         = ttl;
      prot_type_i   = prot;
      source_addr_i = src;
      dest_addr_i   = dst;
      tx_req        = 1'b1;
      req_cyc       = cyc;
      @(posedge clk);
      #1;
      tx_req = 1'b0;
   endtask

   task automatic waitIdle(input string name, input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !tx_busy) break;
      end
      checkOutput({name, "_completes"}, {63'd0, (i < budget)}, 64'd1);
      exp_q.delete();
   endtask

   initial begin
      int e0;
      rst_n = 1'b0; tx_req = 1'b0; send_rdy = 1'b0; payload_len = 16'd0;
      packet_id_i = 16'd0; ttl_i = 8'd0; prot_type_i = 8'd0;
      source_addr_i = 32'd0; dest_addr_i = 32'd0;
      #1;
      checkOutput("reset_outputs",
                  {10'd0, tx_busy, len_err_o, upper_rdy, send_op, send_op_st, send_op_end,
                   send_data, checksum_o}, 64'd0);
      checkOutput("eth_type_in_reset", {48'd0, eth_type_o}, 64'h0800);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send_rdy = 1'b1;

      // Basic frame
      loadTransport(32'hDEADBEEF, 32'h01020304, 0, 0, 2, 2);
      pushHdr(32'h4500001C, 32'h12340000, 32'h4011A7F4, 32'hC0A80001, 32'hFFFFFFFF);
      pushData(32'hDEADBEEF, 32'h01020304, 0, 0, 2);
      applyStimulus(16'd8, 16'h1234, 8'd64, 8'd17, 32'hC0A80001, 32'hFFFFFFFF);
      waitIdle("basic", 100);
      checkOutput("basic_checksum", {48'd0, checksum_o}, 64'hA7F4);
      checkOutput("basic_words_consumed", 64'(t_taken), 64'd2);
      @(posedge clk); #2;
      checkOutput("basic_busy_low", {63'd0, tx_busy}, 64'd0);

      // Backpressure: same frame, send_rdy toggling
      loadTransport(32'hCAFEF00D, 32'h55AA55AA, 0, 0, 2, 2);
      pushHdr(32'h4500001C, 32'h12340000, 32'h4011A7F4, 32'hC0A80001, 32'hFFFFFFFF);
      pushData(32'hCAFEF00D, 32'h55AA55AA, 0, 0, 2);
      bp_mode = 1'b1;
      applyStimulus(16'd8, 16'h1234, 8'd64, 8'd17, 32'hC0A80001, 32'hFFFFFFFF);
      waitIdle("backpressure", 150);
      bp_mode = 1'b0;
      @(posedge clk); #1 send_rdy = 1'b1;
      checkOutput("bp_checksum", {48'd0, checksum_o}, 64'hA7F4);

      // Length rejection
      e0 = err_cnt;
      applyStimulus(16'd0, 16'h1111, 8'd1, 8'd17, 32'h1, 32'h2);
      checkOutput("len0_busy", {63'd0, tx_busy}, 64'd0);
      applyStimulus(16'd1481, 16'h1111, 8'd1, 8'd17, 32'h1, 32'h2);
      checkOutput("len1481_busy", {63'd0, tx_busy}, 64'd0);
      repeat (3) @(posedge clk);
      #2;
      checkOutput("len_err_pulses", 64'(err_cnt - e0), 64'd2);
      checkOutput("len_reject_busy", {63'd0, tx_busy}, 64'd0);

      // Odd length: 5 bytes -> 2 words
      loadTransport(32'hA1B2C3D4, 32'hE5000000, 0, 0, 2, 2);
      pushHdr(32'h45000019, 32'h12340000, 32'h4011A7F7, 32'hC0A80001, 32'hFFFFFFFF);
      pushData(32'hA1B2C3D4, 32'hE5000000, 0, 0, 2);
      applyStimulus(16'd5, 16'h1234, 8'd64, 8'd17, 32'hC0A80001, 32'hFFFFFFFF);
      waitIdle("odd_len", 100);
      checkOutput("odd_checksum", {48'd0, checksum_o}, 64'hA7F7);

      // Early end on word 2 of 4: remaining words padded with zeros
      e0 = err_cnt;
      loadTransport(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 2);
      pushHdr(32'h45000024, 32'h12340000, 32'h4011A7EC, 32'hC0A80001, 32'hFFFFFFFF);
      pushData(32'h11111111, 32'h22222222, 32'h0, 32'h0, 4);
      applyStimulus(16'd16, 16'h1234, 8'd64, 8'd17, 32'hC0A80001, 32'hFFFFFFFF);
      waitIdle("early_end", 100);
      checkOutput("early_end_err", 64'(err_cnt - e0), 64'd1);
      checkOutput("early_end_consumed", 64'(t_taken), 64'd2);
      tq.delete();

      // Reset during DATA word 1
      loadTransport(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4, 0);
      pushHdr(32'h45000024, 32'h12340000, 32'h4011A7EC, 32'hC0A80001, 32'hFFFFFFFF);
      applyStimulus(16'd16, 16'h1234, 8'd64, 8'd17, 32'hC0A80001, 32'hFFFFFFFF);
      repeat (11) @(posedge clk);
      #2;
      checkOutput("pre_reset_data_word", {31'd0, send_op, send_data}, {31'd0, 1'b1, 32'h11111111});
      rst_n = 1'b0;
      #1;
      checkOutput("midframe_reset_outputs",
                  {10'd0, tx_busy, len_err_o, upper_rdy, send_op, send_op_st, send_op_end,
                   send_data, checksum_o}, 64'd0);
      checkOutput("midframe_header_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      tq.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Recovery frame with different fields
      loadTransport(32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 0, 3, 3);
      pushHdr(32'h45000020, 32'hBEEF0000, 32'h801167DB, 32'h0A000001, 32'h0A000002);
      pushData(32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0, 0, 3);
      applyStimulus(16'd12, 16'hBEEF, 8'h80, 8'd17, 32'h0A000001, 32'h0A000002);
      waitIdle("recovery", 100);
      checkOutput("recovery_checksum", {48'd0, checksum_o}, 64'h67DB);
      checkOutput("eth_type", {48'd0, eth_type_o}, 64'h0800);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/network_layer_tx.md
Name: network_layer_tx

Overview:
IPv4 transmit layer, the send-side counterpart of the IPv4 receive path. Accepts a transmit request carrying header fields and payload length, then computes the IPv4 header checksum over several cycles. Emits the 5-word header (IHL=5, no options), then passes transport-layer (UDP) payload words through to the MAC layer as 32-bit words, with start/end framing and a ready/valid handshake.

Parameters:
MAX_PAYLOAD, 1480, largest accepted payload_len in bytes; must be ≤ 65515.
DEF_FLAGS, 3'b000, IPv4 flags field placed in header word 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tx_req  in  1  start pulse; all header inputs are sampled when tx_req=1 in IDLE
payload_len  in  16  IP payload length in bytes (UDP header + data)
packet_id_i  in  16  IPv4 identification
ttl_i  in  8  time to live
prot_type_i  in  8  upper protocol (17 = UDP)
source_addr_i  in  32  source IP
dest_addr_i  in  32  destination IP
tx_busy  out  1  high in every state except IDLE
len_err_o  out  1  one-cycle error pulse (bad length or early upper_op_end)
upper_rdy  out  1  block consumes upper_data this cycle if upper_op=1
upper_op  in  1  upper_data valid
upper_op_end  in  1  last payload word marker from transport
upper_data  in  32  payload word, big-endian byte order
send_op_st  out  1  first word of frame (with send_op)
send_op  out  1  send_data valid
send_op_end  out  1  last word of frame (with send_op)
send_data  out  32  IP word to MAC
send_rdy  in  1  MAC accepts word; a transfer occurs when send_op & send_rdy
eth_type_o  out  16  constant 16'h0800
checksum_o  out  16  checksum of the current or last frame

Behaviour:
- Reset: state IDLE; all counters, latched fields and checksum_o = 0. tx_busy, len_err_o, upper_rdy, send_op, send_op_st and send_op_end = 0; send_data = 0.
- Reset mid-frame aborts immediately; no send_op_end is emitted.
- States: IDLE, CALC, FOLD, HDR, DATA, PAD.
- IDLE, length check: tx_req with payload_len==0 or payload_len>MAX_PAYLOAD gives len_err_o=1 for one cycle and stays in IDLE.
- IDLE, valid request: latch the fields; total_len = payload_len+20; nwords = (payload_len+3)>>2; go to CALC.
- tx_req outside IDLE: ignored.
- Header words:
  - w0 = {4'h4, 4'h5, 8'h00, total_len}
  - w1 = {packet_id, DEF_FLAGS, 13'h0}
  - w2 = {ttl, prot, 16'h0000}
  - w3 = src
  - w4 = dst
- CALC: 5 cycles, one word per cycle. 20-bit accumulator += w[31:16] + w[15:0], with the checksum field taken as zero.
- FOLD: 1 cycle. s = acc[15:0] + acc[19:16]; s = s[15:0] + s[16]; checksum_o = ~s. Go to HDR.
- Latency: the first header word is presented (send_op=1, send_op_st=1) 7 cycles after the cycle in which tx_req was sampled.
- HDR: present w0..w4 in order (w2 carries checksum_o in [15:0]). The word index advances only on a transfer. send_data and the flags stay stable while send_rdy=0. send_op_st is high only with w0. After w4 transfers, go to DATA.
- DATA:
  - upper_rdy = send_rdy, send_op = upper_op, send_data = upper_data (combinational pass-through).
  - The word counter increments on upper_op & send_rdy.
  - send_op_end = 1 on word number nwords.
  - Return to IDLE after that transfer. Any upper_op_end on that word, or its absence, is not checked.
- Early end: upper_op_end on a transferred word before word nwords gives len_err_o pulse, state PAD.
- PAD: upper_rdy=0; emit zero words under send_rdy handshake up to nwords, send_op_end on the last; then IDLE.
- Trailing bytes of the last word beyond payload_len are passed unchanged; the transport zero-fills them.
- Outside DATA: upper_rdy=0 and transport words are not consumed.
- eth_type_o is constant 16'h0800 at all times, including reset.

Test Plan:
- Basic frame:
  - Stimulus: payload_len=8, id=0x1234, ttl=64, prot=17, src=0xC0A80001, dst=0xFFFFFFFF, send_rdy=1; two data words.
  - Required: send_op_st 7 cycles after tx_req. Words 0x4500001C, 0x12340000, 0x4011A7F4, 0xC0A80001, 0xFFFFFFFF, d0, d1. send_op_end on d1; checksum_o=0xA7F4; tx_busy drops after d1.
- Backpressure: same frame, send_rdy toggled 1/0 each cycle -> identical word sequence; send_data held while send_rdy=0; upper_rdy follows send_rdy in DATA.
- Length rejection: payload_len=0, then 1481 -> len_err_o pulse each time; send_op never asserts; tx_busy stays 0.
- Odd length: payload_len=5 -> total_len field 0x0019; exactly 2 data words; send_op_end on the second.
- Early end: payload_len=16, upper_op_end on data word 2 -> len_err_o pulse; words 3 and 4 are 0x00000000; send_op_end on word 4; upper_rdy=0 during padding.
- Reset mid-frame: rst_n low during DATA word 1 -> all outputs 0 immediately. After release, a new tx_req produces a full correct frame.
